// File: rtl/gshare_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gshare_pkg
//  Purpose  : Shared widths and helper functions for the gshare predictor.
//             Helpers work on 32-bit values with the real width passed in.
//             Callers cast the result back down to their own width.
//  Revision : 1.0  initial release
// ============================================================================
package gshare_pkg;

    localparam int c_DEF_PC_W   = 7;
    localparam int c_DEF_IDX_W  = 7;
    localparam int c_DEF_HIST_W = 7;
    localparam int c_DEF_CTR_W  = 2;

    // Saturating up/down step of a ctr_w-bit counter.
    function automatic logic [31:0] ctr_next(input logic [31:0] ctr,
                                             input logic        taken,
                                             input int          ctr_w);
        logic [31:0] max_v;
        max_v = (32'd1 << ctr_w) - 32'd1;
        if (taken)
            return (ctr >= max_v) ? max_v : ctr + 32'd1;
        else
            return (ctr == 32'd0) ? 32'd0 : ctr - 32'd1;
    endfunction

    // Weakly not-taken: one below the taken threshold.
    function automatic logic [31:0] ctr_reset_val(input int ctr_w);
        return (32'd1 << (ctr_w - 1)) - 32'd1;
    endfunction

    // PC low bits XOR zero-extended history, masked to idx_w bits.
    function automatic logic [31:0] gshare_idx(input logic [31:0] pc,
                                               input logic [31:0] hist,
                                               input int          idx_w);
        logic [31:0] mask;
        mask = (32'd1 << idx_w) - 32'd1;
        return (pc ^ hist) & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gshare_predictor_param_if.sv
`default_nettype none
// ============================================================================
//  Module   : gshare_predictor_param_if
//  Purpose  : Predict/train bundle between the front end and the predictor.
//  Ports    : master = pipeline side (drives requests, reads prediction)
//             slave  = predictor side
//  Revision : 1.0  initial release
// ============================================================================
interface gshare_predictor_param_if #(
    parameter int PC_W   = gshare_pkg::c_DEF_PC_W,
    parameter int HIST_W = gshare_pkg::c_DEF_HIST_W
);
    logic              predict_valid;
    logic [PC_W-1:0]   predict_pc;
    logic              predict_taken;
    logic [HIST_W-1:0] predict_history;
    logic              train_valid;
    logic              train_taken;
    logic              train_mispredicted;
    logic [HIST_W-1:0] train_history;
    logic [PC_W-1:0]   train_pc;

    modport master (
        output predict_valid, predict_pc,
        output train_valid, train_taken, train_mispredicted, train_history, train_pc,
        input  predict_taken, predict_history
    );

    modport slave (
        input  predict_valid, predict_pc,
        input  train_valid, train_taken, train_mispredicted, train_history, train_pc,
        output predict_taken, predict_history
    );
endinterface
`default_nettype wire

// File: rtl/gshare_pht.sv
`default_nettype none
// ============================================================================
//  Module   : gshare_pht
//  Purpose  : Pattern history table of saturating counters. One async read
//             port (returns counter MSB) and one sync saturating-update port.
//             Every entry resets in a single cycle to weakly not-taken.
//  Ports    : clk, areset (sync, active high)
//             i_rd_idx / o_rd_taken          : read port
//             i_wr_en / i_wr_idx / i_wr_taken : training port
//  Macro    : GSHARE_PHT_BYPASS_EN - forward the post-update counter MSB to
//             the read port when read and write hit the same entry.
//  Revision : 1.0  initial release
// ============================================================================
module gshare_pht
    import gshare_pkg::*;
#(
    parameter int IDX_W = c_DEF_IDX_W,
    parameter int CTR_W = c_DEF_CTR_W
) (
    input  logic             clk,
    input  logic             areset,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic             o_rd_taken,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic             i_wr_taken
);
    localparam int               c_DEPTH   = 2 ** IDX_W;
    localparam logic [CTR_W-1:0] c_RST_VAL = CTR_W'(ctr_reset_val(CTR_W));

    logic [CTR_W-1:0] r_pht [c_DEPTH];
    logic [CTR_W-1:0] w_upd;

    assign w_upd = CTR_W'(ctr_next(32'(r_pht[i_wr_idx]), i_wr_taken, CTR_W));

    always_ff @(posedge clk) begin
        if (areset) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_pht[i] <= c_RST_VAL;
            end
        end else if (i_wr_en) begin
            r_pht[i_wr_idx] <= w_upd;
        end
    end

`ifdef GSHARE_PHT_BYPASS_EN
    logic w_bypass_hit;
    assign w_bypass_hit = i_wr_en && (i_wr_idx == i_rd_idx);
    assign o_rd_taken   = w_bypass_hit ? w_upd[CTR_W-1] : r_pht[i_rd_idx][CTR_W-1];
`else
    // Same-cycle write is not visible until the next cycle.
    assign o_rd_taken = r_pht[i_rd_idx][CTR_W-1];
`endif

endmodule
`default_nettype wire

// File: rtl/gshare_predictor_param.sv
`default_nettype none
// ============================================================================
//  Module   : gshare_predictor_param
//  Purpose  : Parametrised gshare direction predictor. Holds the global
//             history register and its update priority, and owns the PHT.
//             Prediction is combinational; training is at posedge.
//  Ports    : clk, areset (sync, active high)
//             bus (slave modport of gshare_predictor_param_if):
//               predict_valid/predict_pc -> predict_taken/predict_history
//               train_valid/taken/mispredicted/history/pc
//  Macro    : GSHARE_PHT_BYPASS_EN - same-entry train->predict forwarding
//             inside gshare_pht (history behaviour unchanged).
//  Revision : 1.0  initial release
// ============================================================================
module gshare_predictor_param
    import gshare_pkg::*;
#(
    parameter int PC_W   = c_DEF_PC_W,
    parameter int IDX_W  = c_DEF_IDX_W,
    parameter int HIST_W = c_DEF_HIST_W,
    parameter int CTR_W  = c_DEF_CTR_W
) (
    input  logic                     clk,
    input  logic                     areset,
    gshare_predictor_param_if.slave  bus
);
    logic [HIST_W-1:0] r_ghr;
    logic [IDX_W-1:0]  w_rd_idx;
    logic [IDX_W-1:0]  w_wr_idx;
    logic              w_pred_taken;

    assign w_rd_idx = IDX_W'(gshare_idx(32'(bus.predict_pc), 32'(r_ghr), IDX_W));
    assign w_wr_idx = IDX_W'(gshare_idx(32'(bus.train_pc), 32'(bus.train_history), IDX_W));

    gshare_pht #(
        .IDX_W (IDX_W),
        .CTR_W (CTR_W)
    ) u_pht (
        .clk        (clk),
        .areset     (areset),
        .i_rd_idx   (w_rd_idx),
        .o_rd_taken (w_pred_taken),
        .i_wr_en    (bus.train_valid),
        .i_wr_idx   (w_wr_idx),
        .i_wr_taken (bus.train_taken)
    );

    assign bus.predict_taken   = w_pred_taken;
    assign bus.predict_history = r_ghr;

    // Misprediction recovery rebuilds history from the branch's own snapshot
    // and discards any speculative shift from a same-cycle prediction.
    always_ff @(posedge clk) begin
        if (areset) begin
            r_ghr <= '0;
        end else if (bus.train_valid && bus.train_mispredicted) begin
            r_ghr <= {bus.train_history[HIST_W-2:0], bus.train_taken};
        end else if (bus.predict_valid) begin
            r_ghr <= {r_ghr[HIST_W-2:0], w_pred_taken};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gshare_predictor_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gshare_predictor_param
//  Purpose  : Self-checking bench: default instance (7/7/7/2) and a wide
//             instance (10/9/5/3). Directed tables plus randomized traffic
//             against a behavioural model on the default instance.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gshare_predictor_param;

`ifdef GSHARE_PHT_BYPASS_EN
    localparam logic c_BYP = 1'b1;
`else
    localparam logic c_BYP = 1'b0;
`endif

    logic clk;
    logic areset;
    int   n_pass;
    int   n_total;

    gshare_predictor_param_if #(.PC_W(7),  .HIST_W(7)) b1 ();
    gshare_predictor_param_if #(.PC_W(10), .HIST_W(5)) b2 ();

    gshare_predictor_param #(.PC_W(7), .IDX_W(7), .HIST_W(7), .CTR_W(2)) u_dut1 (
        .clk    (clk),
        .areset (areset),
        .bus    (b1.slave)
    );

    gshare_predictor_param #(.PC_W(10), .IDX_W(9), .HIST_W(5), .CTR_W(3)) u_dut2 (
        .clk    (clk),
        .areset (areset),
        .bus    (b2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pv;
        logic [15:0] pc;
        logic        tv;
        logic        tt;
        logic        tm;
        logic [15:0] th;
        logic [15:0] tpc;
        logic        et;
        logic [15:0] eh;
    } vec_t;

    vec_t t1[$];
    vec_t t2[$];

    // Behavioural model of the default instance.
    int m_pht[128];
    int m_ghr;

    function automatic vec_t mk(input logic pv, input int pc, input logic tv,
                                input logic tt, input logic tm, input int th,
                                input int tpc, input logic et, input int eh);
        vec_t v;
        v.pv = pv; v.pc = 16'(pc); v.tv = tv; v.tt = tt; v.tm = tm;
        v.th = 16'(th); v.tpc = 16'(tpc); v.et = et; v.eh = 16'(eh);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else
            n_pass++;
    endtask

    task automatic drive1(input vec_t v);
        b1.predict_valid      = v.pv;
        b1.predict_pc         = v.pc[6:0];
        b1.train_valid        = v.tv;
        b1.train_taken        = v.tt;
        b1.train_mispredicted = v.tm;
        b1.train_history      = v.th[6:0];
        b1.train_pc           = v.tpc[6:0];
    endtask

    task automatic drive2(input vec_t v);
        b2.predict_valid      = v.pv;
        b2.predict_pc         = v.pc[9:0];
        b2.train_valid        = v.tv;
        b2.train_taken        = v.tt;
        b2.train_mispredicted = v.tm;
        b2.train_history      = v.th[4:0];
        b2.train_pc           = v.tpc[9:0];
    endtask

    function automatic logic model_pred(input int pc, input logic tv, input logic tt,
                                        input int th, input int tpc);
        int ri;
        int c;
        ri = (pc ^ m_ghr) % 128;
        c  = m_pht[ri];
        if (c_BYP && tv && (((tpc ^ th) % 128) == ri))
            c = tt ? ((c == 3) ? 3 : c + 1) : ((c == 0) ? 0 : c - 1);
        return (c >= 2);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 128; i++) m_pht[i] = 1;
        m_ghr = 0;
    endtask

    initial begin
        vec_t idle;
        n_pass  = 0;
        n_total = 0;
        idle    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive1(idle);
        drive2(idle);

        // Reset held while training/predicting on instance 1: reset must win.
        areset = 1'b1;
        drive1(mk(1, 7'h11, 1, 1, 1, 7'h7F, 7'h03, 0, 0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        areset = 1'b0;
        drive1(mk(0, 7'h7C, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("rst_taken_trained_entry", 32'(b1.predict_taken), 32'd0);
        chk("rst_history", 32'(b1.predict_history), 32'd0);
        chk("rst2_history", 32'(b2.predict_history), 32'd0);

        // Wide instance: reset value 3, threshold 4, 9-bit index, 5-bit history.
        t2.push_back(mk(0, 10'h155, 0, 0, 0, 0,     0,      0,           5'h00));
        t2.push_back(mk(0, 10'h155, 1, 0, 1, 5'h13, 10'h2AB, 0,          5'h00));
        t2.push_back(mk(0, 10'h2A6, 1, 1, 0, 5'h06, 10'h0A6, c_BYP,      5'h06));
        t2.push_back(mk(0, 10'h2A6, 0, 0, 0, 0,     0,      1,           5'h06));
        t2.push_back(mk(0, 10'h0A6, 1, 0, 0, 5'h06, 10'h0A6, !c_BYP,     5'h06));
        t2.push_back(mk(0, 10'h0A6, 0, 0, 0, 0,     0,      0,           5'h06));
        t2.push_back(mk(1, 10'h0BE, 0, 0, 0, 0,     0,      0,           5'h06));
        t2.push_back(mk(0, 10'h000, 0, 0, 0, 0,     0,      0,           5'h0C));
        for (int i = 0; i < t2.size(); i++) begin
            if (i != 0) @(negedge clk);
            drive2(t2[i]);
            #1;
            chk($sformatf("w%0d_taken", i), 32'(b2.predict_taken), 32'(t2[i].et));
            chk($sformatf("w%0d_hist", i), 32'(b2.predict_history), 32'(t2[i].eh));
            @(posedge clk);
        end
        @(negedge clk);
        drive2(idle);

        // Default instance directed table.
        t1.push_back(mk(1, 7'h15, 0, 0, 0, 0,     0,     0, 7'h00));
        t1.push_back(mk(0, 7'h00, 1, 1, 0, 0,     7'h03, 0, 7'h00));
        t1.push_back(mk(0, 7'h00, 1, 1, 0, 0,     7'h03, 0, 7'h00));
        t1.push_back(mk(0, 7'h03, 0, 0, 0, 0,     0,     1, 7'h00));
        for (int k = 0; k < 5; k++)
            t1.push_back(mk(0, 7'h03, 1, 1, 0, 0, 7'h03, 1, 7'h00));
        t1.push_back(mk(0, 7'h03, 1, 0, 0, 0,     7'h03, 1,      7'h00));
        t1.push_back(mk(0, 7'h03, 1, 0, 0, 0,     7'h03, !c_BYP, 7'h00));
        for (int k = 0; k < 3; k++)
            t1.push_back(mk(0, 7'h03, 1, 0, 0, 0, 7'h03, 0, 7'h00));
        t1.push_back(mk(0, 7'h03, 0, 0, 0, 0,     0,     0,     7'h00));
        t1.push_back(mk(1, 7'h15, 1, 1, 1, 7'h2A, 7'h40, 0,     7'h00));
        t1.push_back(mk(0, 7'h00, 0, 0, 0, 0,     0,     0,     7'h55));
        t1.push_back(mk(0, 7'h55, 1, 1, 0, 0,     7'h00, c_BYP, 7'h55));
        t1.push_back(mk(0, 7'h55, 0, 0, 0, 0,     0,     1,     7'h55));
        t1.push_back(mk(1, 7'h55, 0, 0, 0, 0,     0,     1,     7'h55));
        t1.push_back(mk(0, 7'h00, 0, 0, 0, 0,     0,     0,     7'h2B));
        for (int i = 0; i < t1.size(); i++) begin
            @(negedge clk);
            drive1(t1[i]);
            #1;
            chk($sformatf("d%0d_taken", i), 32'(b1.predict_taken), 32'(t1[i].et));
            chk($sformatf("d%0d_hist", i), 32'(b1.predict_history), 32'(t1[i].eh));
            @(posedge clk);
        end

        // Randomized traffic against the model, starting from a fresh reset.
        @(negedge clk);
        drive1(idle);
        areset = 1'b1;
        @(posedge clk);
        model_reset();
        for (int n = 0; n < 600; n++) begin
            int   pc, th, tpc;
            logic pv, tv, tt, tm, rst, ep;
            @(negedge clk);
            pc  = int'($urandom_range(0, 127));
            pv  = 1'($urandom_range(0, 1));
            tv  = 1'($urandom_range(0, 1));
            tt  = 1'($urandom_range(0, 1));
            tm  = ($urandom_range(0, 3) == 0);
            th  = ($urandom_range(0, 1) == 1) ? m_ghr : int'($urandom_range(0, 127));
            tpc = ($urandom_range(0, 1) == 1) ? pc : int'($urandom_range(0, 7));
            rst = ($urandom_range(0, 63) == 0);
            areset = rst;
            drive1(mk(pv, pc, tv, tt, tm, th, tpc, 0, 0));
            #1;
            ep = model_pred(pc, tv, tt, th, tpc);
            chk($sformatf("r%0d_taken", n), 32'(b1.predict_taken), 32'(ep));
            chk($sformatf("r%0d_hist", n), 32'(b1.predict_history), 32'(m_ghr));
            @(posedge clk);
            if (rst) begin
                model_reset();
            end else begin
                if (tv) begin
                    int wi;
                    wi = (tpc ^ th) % 128;
                    if (tt) m_pht[wi] = (m_pht[wi] == 3) ? 3 : m_pht[wi] + 1;
                    else    m_pht[wi] = (m_pht[wi] == 0) ? 0 : m_pht[wi] - 1;
                end
                if (tv && tm)  m_ghr = ((th * 2) + int'(tt)) % 128;
                else if (pv)   m_ghr = ((m_ghr * 2) + int'(ep)) % 128;
            end
        end

        @(negedge clk);
        areset = 1'b0;
        drive1(idle);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gshare_predictor_param.md
Name: gshare_predictor_param

Overview:
Parametrised next-generation gshare branch direction predictor for the front-end fetch stage. It keeps a global branch history register (GHR) and a pattern history table (PHT) of saturating counters indexed by PC XOR history. It predicts combinationally in the fetch cycle and trains from the execute stage. Unlike the fixed 7-bit predictor, it generalises PC, history, index and counter widths and restores history on a misprediction.

Parameters:
PC_W, 7, width of predict_pc/train_pc; must be >= IDX_W
IDX_W, 7, PHT index width; PHT depth = 2**IDX_W
HIST_W, 7, GHR width; must be <= IDX_W
CTR_W, 2, saturating counter width; must be >= 2

Ports:
clk  in  1  clock; all state updates on posedge
areset  in  1  synchronous active-high reset (despite the name, sampled only on posedge clk)
predict_valid  in  1  fetch-stage prediction request
predict_pc  in  PC_W  PC of branch being predicted
predict_taken  out  1  predicted direction
predict_history  out  HIST_W  GHR value used for this prediction (travels with branch down pipeline)
train_valid  in  1  execute-stage training request
train_taken  in  1  resolved direction
train_mispredicted  in  1  resolved direction differed from prediction
train_history  in  HIST_W  GHR value returned with the branch (its predict_history)
train_pc  in  PC_W  PC of resolved branch

Behaviour:
- Index function: idx(pc,h) = pc[IDX_W-1:0] XOR zero-extend(h to IDX_W).
- Prediction, combinational, zero latency: predict_taken = MSB of PHT[idx(predict_pc, GHR)]; predict_history = GHR. Outputs are driven every cycle regardless of predict_valid.
- Training, applied at posedge when train_valid=1: PHT[idx(train_pc, train_history)] increments if train_taken=1, else decrements. Saturates at 2**CTR_W-1 and at 0.
- GHR next-state, in priority order:
  1. areset: 0.
  2. train_valid & train_mispredicted: {train_history[HIST_W-2:0], train_taken}. This is recovery and overrides any same-cycle prediction.
  3. predict_valid: {GHR[HIST_W-2:0], predict_taken}.
  4. otherwise: hold.
- Training without misprediction never modifies the GHR.
- Same-cycle train and predict to the same PHT entry: the prediction reads the pre-update counter (no bypass unless the optional feature is compiled in).
- Reset: every PHT entry = 2**(CTR_W-1)-1 (weakly not-taken; 01 for CTR_W=2); GHR = 0.
  - Post-reset outputs: predict_taken=0, predict_history=0.
  - Reset dominates all simultaneous train/predict activity.
  - The PHT reset completes in the single reset cycle; no multi-cycle init sequencer.
- Outputs are purely combinational from registered state and inputs; there are no output registers.

Optional Feature:
Macro GSHARE_PHT_BYPASS_EN.
- Defined: if train_valid and idx(train_pc, train_history) == idx(predict_pc, GHR) in the same cycle, predict_taken uses the post-update (saturated) counter MSB. This forwarding adds a comparator and mux on the predict path.
- Undefined: prediction reads the stored counter, as described above.
- GHR behaviour is identical either way.

Decomposition:
- Package gshare_pkg:
  - Default width localparams.
  - Function ctr_next(ctr, taken) implementing saturating increment/decrement.
  - Function ctr_reset_val.
  - Function gshare_idx.
- Sub-module gshare_pht:
  - Counter array with one async read port and one sync write port with saturating update, plus reset.
  - Hosts the bypass logic under the macro.
- The top module holds the GHR and its priority mux.

Test Plan:
- Reset then predict_valid=1, predict_pc=7'h15 -> predict_taken=0, predict_history=0; next cycle GHR=7'h00 (shifted-in 0).
- Train pc=7'h03, history=0, taken=1, not mispredicted, twice -> PHT[3] goes 01->10->11; predict pc=7'h03 with GHR=0 -> taken=1; GHR unchanged by training.
- Train taken=1 five times on one entry -> saturates at 11. Train not-taken five times -> saturates at 00; no wrap.
- Same cycle: predict_valid=1 and train_valid=1, mispredicted=1, train_history=7'h2A, taken=1 -> next GHR=7'h55, prediction shift discarded.
- Same-cycle train/predict on the same index with counter 01 and train taken:
  - macro off -> predict_taken=0;
  - GSHARE_PHT_BYPASS_EN -> predict_taken=1.
- Non-default parameters PC_W=10, IDX_W=9, HIST_W=5, CTR_W=3 -> reset counters=3; index = pc[8:0]^{4'b0,hist}; threshold at counter 4.
